// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants and state type for the text tile engine
package text_pkg;

    localparam int CHAR_W = 7;
    localparam int FONT_W = 8;
    localparam int FONT_H = 16;
    localparam int ROM_AW = 11;

    localparam logic [CHAR_W-1:0] CHAR_BLANK = 7'h00;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } tstate_t;

endpackage

// File: rtl/ascii_rom.sv
// rtl/ascii_rom.sv - 8x16 glyph ROM with registered output; unlisted codes read blank
module ascii_rom
    import text_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [FONT_W-1:0] o_data
);

    logic [FONT_W-1:0] w_row;
    logic [FONT_W-1:0] r_data;

    // Glyph lookup: addr = {code, glyph_row}, MSB is the leftmost pixel
    always_comb begin
        w_row = '0;
        case (i_addr[10:4])
            7'h41: begin
                case (i_addr[3:0])
                    4'h2:                      w_row = 8'h10;
                    4'h3:                      w_row = 8'h38;
                    4'h4:                      w_row = 8'h6C;
                    4'h5, 4'h6:                w_row = 8'hC6;
                    4'h7:                      w_row = 8'hFE;
                    4'h8, 4'h9, 4'hA, 4'hB:    w_row = 8'hC6;
                    default:                   w_row = 8'h00;
                endcase
            end
            7'h42: begin
                case (i_addr[3:0])
                    4'h2, 4'hB:                w_row = 8'hFC;
                    4'h3, 4'h4, 4'h5:          w_row = 8'h66;
                    4'h6:                      w_row = 8'h7C;
                    4'h7, 4'h8, 4'h9, 4'hA:    w_row = 8'h66;
                    default:                   w_row = 8'h00;
                endcase
            end
            default: w_row = '0;
        endcase
    end

    // Synchronous ROM read
    always_ff @(posedge clk) begin
        r_data <= w_row;
    end

    assign o_data = r_data;

endmodule

// File: rtl/text_char_buf.sv
// rtl/text_char_buf.sv - simple dual-port character RAM, registered read-first port
module text_char_buf #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write and registered read share one edge, so a same-cell read sees the old value
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_tile_engine.sv
// rtl/text_tile_engine.sv - character-buffer text overlay; optional blink via TEXT_BLINK_EN
module text_tile_engine
    import text_pkg::*;
#(
    parameter int          COLS       = 32,
    parameter int          ROWS       = 4,
    parameter int          SCALE_LOG2 = 1,
    parameter int          X0         = 0,
    parameter int          Y0         = 32,
    parameter logic [11:0] FG         = 12'hFFF,
    parameter logic [11:0] BG         = 12'h000,
    parameter int          BLINK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [5:0]  wr_col,
    input  logic [3:0]  wr_row,
    input  logic [7:0]  wr_char,
    input  logic        clr,
    output logic        busy,
    output logic        text_on,
    output logic [11:0] text_rgb
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int S     = SCALE_LOG2;
    localparam int WIN_W = COLS << (3 + S);
    localparam int WIN_H = ROWS << (4 + S);
`ifdef TEXT_BLINK_EN
    localparam int DW    = 8;
`else
    localparam int DW    = CHAR_W;
`endif

    tstate_t           r_state;
    logic [AW-1:0]     r_clr_cnt;

    logic              w_wr_in_range;
    logic              w_wr_fire;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DW-1:0]     w_wdata;
    logic [DW-1:0]     w_wr_data;

    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic              w_win;
    logic [5:0]        w_col;
    logic [3:0]        w_row;
    logic [3:0]        w_grow;
    logic [2:0]        w_bit;
    logic [AW-1:0]     w_raddr;
    logic [DW-1:0]     w_rd_data;
    logic [ROM_AW-1:0] w_rom_addr;
    logic [FONT_W-1:0] w_rom_data;
    logic              w_blank_s1;

    logic              r_s1_win;
    logic [3:0]        r_s1_grow;
    logic [2:0]        r_s1_bit;
    logic              r_s2_win;
    logic [2:0]        r_s2_bit;
    logic              r_s2_blank;
    logic              r_text_on;
    logic [11:0]       r_text_rgb;

    // Clear sequencer: sweeps every cell once, restarting on any clr pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr) begin
                        r_clr_cnt <= '0;
                    end else if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        r_state   <= IDLE;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_cnt <= '0;
                end
            endcase
        end
    end

    assign busy     = (r_state == CLEAR);
    assign wr_ready = (r_state == IDLE) && !clr;

    // Out-of-range writes still handshake but never touch the RAM
    assign w_wr_in_range = (32'(wr_col) < 32'(COLS)) && (32'(wr_row) < 32'(ROWS));
    assign w_wr_fire     = wr_valid && wr_ready && w_wr_in_range;

    assign w_we    = busy || w_wr_fire;
    assign w_waddr = busy ? r_clr_cnt : AW'(32'(wr_row) * 32'(COLS) + 32'(wr_col));
    assign w_wdata = busy ? DW'(CHAR_BLANK) : w_wr_data;

    // Window-relative coordinates; a negative offset wraps high and falls outside
    assign w_dx   = {1'b0, x} - 11'(X0);
    assign w_dy   = {1'b0, y} - 11'(Y0);
    assign w_win  = (32'(w_dx) < 32'(WIN_W)) && (32'(w_dy) < 32'(WIN_H));
    assign w_col  = 6'(w_dx >> (3 + S));
    assign w_row  = 4'(w_dy >> (4 + S));
    assign w_grow = w_dy[S+3:S];
    assign w_bit  = w_dx[S+2:S];

    // Outside the window the address is parked at 0 so it never exceeds DEPTH
    assign w_raddr = w_win ? AW'(32'(w_row) * 32'(COLS) + 32'(w_col)) : '0;

    text_char_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_data)
    );

    assign w_rom_addr = {w_rd_data[CHAR_W-1:0], r_s1_grow};

    ascii_rom u_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

`ifdef TEXT_BLINK_EN
    logic [BLINK_LOG2:0] r_frame_cnt;

    // Frame counter advances once per frame on the top-left pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (x == 10'd0 && y == 10'd0) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_wr_data  = wr_char;
    assign w_blank_s1 = w_rd_data[7] && r_frame_cnt[BLINK_LOG2];
`else
    logic w_unused_attr;
    localparam int unused_blink_log2 = BLINK_LOG2;

    assign w_unused_attr = wr_char[7];
    assign w_wr_data     = wr_char[CHAR_W-1:0];
    assign w_blank_s1    = 1'b0;
`endif

    // Side-band pipeline: carries window flag and glyph coordinates alongside the RAM/ROM reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_win   <= 1'b0;
            r_s1_grow  <= '0;
            r_s1_bit   <= '0;
            r_s2_win   <= 1'b0;
            r_s2_bit   <= '0;
            r_s2_blank <= 1'b0;
        end else begin
            r_s1_win   <= w_win;
            r_s1_grow  <= w_grow;
            r_s1_bit   <= w_bit;
            r_s2_win   <= r_s1_win;
            r_s2_bit   <= r_s1_bit;
            r_s2_blank <= w_blank_s1;
        end
    end

    // Output stage: bit 0 of a tile column is the glyph MSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_text_on  <= 1'b0;
            r_text_rgb <= BG;
        end else begin
            r_text_on  <= r_s2_win;
            r_text_rgb <= (r_s2_win && w_rom_data[~r_s2_bit] && !r_s2_blank) ? FG : BG;
        end
    end

    assign text_on  = r_text_on;
    assign text_rgb = r_text_rgb;

endmodule
